y86_execute_cc: RTL and testbench

Execute-stage ALU and condition-code unit for the Y86-64 pipeline. It consumes decoded operands and function code, computes `valE` using the 64-bit add/sub/and/xor datapath, and updates the architectural condition codes (ZF, SF, OF). It evaluates jXX/cmovXX conditions against the current codes and presents a registered result to the memory stage through a valid/ready handshake.

---
 rtl/y86_execute_cc.sv | 108 ++++++++++
 tb/tb_y86_execute_cc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_execute_cc.sv
// Y86-64 execute stage: add/sub/and/xor ALU, ZF/SF/OF condition codes, jXX/cmovXX evaluation.
// Latency 1 cycle, one result per cycle; or/andn ops for ifun 4/5 when Y86_ALU_EXT_OPS_EN is defined.
// Backpressure: result register holds while out_valid && !out_ready; in_ready drops until it drains.
module y86_execute_cc #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_aluA,
    input  logic [W-1:0] in_aluB,
    input  logic         in_set_cc,
    input  logic         in_cond_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_valE,
    output logic         out_cnd,
    output logic         out_err,
    output logic [2:0]   cc_o
);

    typedef struct packed {
        logic [W-1:0] vale;
        logic         cnd;
        logic         err;
    } res_t;

    res_t         res_d, res_q;
    logic [W-1:0] sum, diff;
    logic [2:0]   cc_q;
    logic         zf, sf, of, of_d, accept, cc_we;

    assign {zf, sf, of} = cc_q;

    always_comb begin
        sum   = in_aluB + in_aluA;
        diff  = in_aluB - in_aluA;
        res_d = '0;
        of_d  = 1'b0;
        if (in_cond_en) begin
            res_d.vale = sum;
            case (in_ifun)
                4'd0:    res_d.cnd = 1'b1;
                4'd1:    res_d.cnd = (sf ^ of) | zf;
                4'd2:    res_d.cnd = sf ^ of;
                4'd3:    res_d.cnd = zf;
                4'd4:    res_d.cnd = ~zf;
                4'd5:    res_d.cnd = ~(sf ^ of);
                4'd6:    res_d.cnd = ~(sf ^ of) & ~zf;
                default: res_d.err = 1'b1;
            endcase
        end else begin
            case (in_ifun)
                4'd0: begin
                    res_d.vale = sum;
                    of_d = (in_aluA[W-1] == in_aluB[W-1]) && (sum[W-1] != in_aluA[W-1]);
                end
                4'd1: begin
                    res_d.vale = diff;
                    of_d = (in_aluA[W-1] != in_aluB[W-1]) && (diff[W-1] != in_aluB[W-1]);
                end
                4'd2:    res_d.vale = in_aluB & in_aluA;
                4'd3:    res_d.vale = in_aluB ^ in_aluA;
`ifdef Y86_ALU_EXT_OPS_EN
                4'd4:    res_d.vale = in_aluB | in_aluA;
                4'd5:    res_d.vale = in_aluB & ~in_aluA;
`endif
                default: res_d.err = 1'b1;
            endcase
        end
        // An illegal op still travels downstream, but carries no result.
        if (res_d.err) begin
            res_d.vale = '0;
            res_d.cnd  = 1'b0;
            of_d       = 1'b0;
        end
    end

    assign in_ready = !reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign cc_we    = accept && in_set_cc && !in_cond_en && !res_d.err;

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q     <= '0;
            out_valid <= 1'b0;
            cc_q      <= 3'b100;
        end else begin
            if (accept) begin
                res_q     <= res_d;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (cc_we) begin
                cc_q <= {res_d.vale == '0, res_d.vale[W-1], of_d};
            end
        end
    end

    assign out_valE = res_q.vale;
    assign out_cnd  = res_q.cnd;
    assign out_err  = res_q.err;
    assign cc_o     = cc_q;

endmodule

// File: tb/tb_y86_execute_cc.sv
// Bench for y86_execute_cc: directed vector table, handshake/reset sequences, randomized model check.
module tb_y86_execute_cc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_set_cc, in_cond_en;
    logic [3:0]  in_ifun;
    logic [63:0] in_aluA, in_aluB;
    logic        out_valid, out_ready, out_cnd, out_err;
    logic [63:0] out_valE;
    logic [2:0]  cc_o;

    int n_pass = 0;
    int n_total = 0;

    y86_execute_cc #(.W(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ifun(in_ifun),
        .in_aluA(in_aluA), .in_aluB(in_aluB), .in_set_cc(in_set_cc), .in_cond_en(in_cond_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_valE(out_valE),
        .out_cnd(out_cnd), .out_err(out_err), .cc_o(cc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] vale;
        logic        cnd;
        logic        err;
        logic [2:0]  flags;
    } res_t;

    typedef struct {
        logic [3:0]  ifun;
        logic [63:0] a, b;
        logic        set_cc, cond_en;
        logic [63:0] vale;
        logic        cnd, err;
        logic [2:0]  cc;
    } vec_t;

    localparam logic signed [64:0] SMAX = {2'b00, {63{1'b1}}};
    localparam logic signed [64:0] SMIN = {2'b11, {63{1'b0}}};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Reference: signed overflow decided by whether the exact 65-bit result fits in 64 bits.
    function automatic res_t ref_exec(input logic [3:0] ifun, input logic [63:0] a, input logic [63:0] b,
                                      input logic cond_en, input logic [2:0] cc);
        res_t r;
        logic signed [64:0] wide;
        logic of;
        bit lt;
        r    = '0;
        of   = 1'b0;
        wide = '0;
        lt   = (cc[1] != cc[0]);
        if (cond_en) begin
            r.vale = a + b;
            case (ifun)
                4'd0: r.cnd = 1'b1;
                4'd1: r.cnd = lt || cc[2];
                4'd2: r.cnd = lt;
                4'd3: r.cnd = cc[2];
                4'd4: r.cnd = !cc[2];
                4'd5: r.cnd = !lt;
                4'd6: r.cnd = !lt && !cc[2];
                default: r.err = 1'b1;
            endcase
        end else begin
            case (ifun)
                4'd0: begin
                    wide = $signed({b[63], b}) + $signed({a[63], a});
                    r.vale = wide[63:0];
                    of = (wide > SMAX) || (wide < SMIN);
                end
                4'd1: begin
                    wide = $signed({b[63], b}) - $signed({a[63], a});
                    r.vale = wide[63:0];
                    of = (wide > SMAX) || (wide < SMIN);
                end
                4'd2: r.vale = b & a;
                4'd3: r.vale = b ^ a;
`ifdef Y86_ALU_EXT_OPS_EN
                4'd4: r.vale = b | a;
                4'd5: r.vale = b & ~a;
`endif
                default: r.err = 1'b1;
            endcase
        end
        if (r.err) begin
            r.vale = '0;
            r.cnd  = 1'b0;
        end
        r.flags = {r.vale == 64'd0, r.vale[63], of};
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] ifun, input logic [63:0] a, input logic [63:0] b,
                                input logic set_cc, input logic cond_en, input logic [63:0] vale,
                                input logic cnd, input logic err, input logic [2:0] cc);
        vec_t v;
        v.ifun = ifun; v.a = a; v.b = b; v.set_cc = set_cc; v.cond_en = cond_en;
        v.vale = vale; v.cnd = cnd; v.err = err; v.cc = cc;
        return v;
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 4))
            0:       return 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            1:       return 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 3));
            2:       return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input logic v, input logic [3:0] ifun, input logic [63:0] a, input logic [63:0] b,
                         input logic set_cc, input logic cond_en);
        in_valid = v; in_ifun = ifun; in_aluA = a; in_aluB = b;
        in_set_cc = set_cc; in_cond_en = cond_en;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs[16];
    int   nvec;
    logic [2:0]  m_cc;
    logic        m_valid, m_cnd, m_err, exp_rdy;
    logic [63:0] m_vale;
    res_t        r;

    initial begin
        // Directed table; each row is accepted with out_ready=1 and checked one edge later.
        nvec = 0;
        vecs[nvec++] = mk(4'd0, 64'd5, 64'd3, 1, 0, 64'd8, 0, 0, 3'b000);
        vecs[nvec++] = mk(4'd3, 64'hF5, 64'hD3, 1, 0, 64'h26, 0, 0, 3'b000);
        vecs[nvec++] = mk(4'd1, 64'h7B, 64'h7B, 1, 0, 64'd0, 0, 0, 3'b100);
        vecs[nvec++] = mk(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0,
                          64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 3'b011);
        vecs[nvec++] = mk(4'd2, 64'd0, 64'h10, 0, 1, 64'h10, 0, 0, 3'b011);
        vecs[nvec++] = mk(4'd1, 64'd0, 64'h10, 0, 1, 64'h10, 0, 0, 3'b011);
        vecs[nvec++] = mk(4'd5, 64'd1, 64'h10, 0, 1, 64'h11, 1, 0, 3'b011);
        vecs[nvec++] = mk(4'd7, 64'd1, 64'h10, 0, 1, 64'd0, 0, 1, 3'b011);
        vecs[nvec++] = mk(4'd0, 64'd1, 64'd2, 1, 1, 64'd3, 1, 0, 3'b011);
        vecs[nvec++] = mk(4'd1, 64'd5, 64'd3, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 3'b010);
        vecs[nvec++] = mk(4'd1, 64'd1, 64'h8000_0000_0000_0000, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 3'b001);
        vecs[nvec++] = mk(4'd0, 64'd1, 64'd1, 0, 0, 64'd2, 0, 0, 3'b001);
        vecs[nvec++] = mk(4'd2, 64'hF0, 64'h0F, 1, 0, 64'd0, 0, 0, 3'b100);
`ifdef Y86_ALU_EXT_OPS_EN
        vecs[nvec++] = mk(4'd4, 64'd1, 64'd2, 1, 0, 64'd3, 0, 0, 3'b000);
        vecs[nvec++] = mk(4'd3, 64'd0, 64'd0, 0, 1, 64'd0, 0, 0, 3'b000);
`else
        vecs[nvec++] = mk(4'd4, 64'd1, 64'd2, 1, 0, 64'd0, 0, 1, 3'b100);
        vecs[nvec++] = mk(4'd3, 64'd0, 64'd0, 0, 1, 64'd0, 1, 0, 3'b100);
`endif

        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_valE", out_valE, 64'd0);
        check("rst_cnd", 64'(out_cnd), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_cc", 64'(cc_o), 64'b100);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            drive(1'b1, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].set_cc, vecs[i].cond_en);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_valE", i), out_valE, vecs[i].vale);
            check($sformatf("vec%0d_cnd", i), 64'(out_cnd), 64'(vecs[i].cnd));
            check($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].err));
            check($sformatf("vec%0d_cc", i), 64'(cc_o), 64'(vecs[i].cc));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain_valid", 64'(out_valid), 64'd0);

        // Stall: first accepted, second blocked, then drain+accept in one edge.
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 64'd1, 64'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("stall_first_valE", out_valE, 64'd2);
        drive(1'b1, 4'd0, 64'd10, 64'd10, 1'b0, 1'b0);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_valE", out_valE, 64'd2);
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("unstall_valid", 64'(out_valid), 64'd1);
        check("unstall_valE", out_valE, 64'd20);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset while holding a stalled result that also changed the codes.
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 64'd5, 64'd3, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_cc", 64'(cc_o), 64'b010);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_cc", 64'(cc_o), 64'b100);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);

        // Randomized traffic against the reference model.
        do_reset();
        m_valid = 1'b0; m_vale = '0; m_cnd = 1'b0; m_err = 1'b0; m_cc = 3'b100;
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6)),
                  rand64(), rand64(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            out_ready = $urandom_range(0, 9) < 7;
            exp_rdy = !m_valid || out_ready;
            #1;
            check("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
            if (in_valid && exp_rdy) begin
                r = ref_exec(in_ifun, in_aluA, in_aluB, in_cond_en, m_cc);
                m_valid = 1'b1; m_vale = r.vale; m_cnd = r.cnd; m_err = r.err;
                if (in_set_cc && !in_cond_en && !r.err) m_cc = r.flags;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("rnd_valid", 64'(out_valid), 64'(m_valid));
            check("rnd_cc", 64'(cc_o), 64'(m_cc));
            if (m_valid) begin
                check("rnd_valE", out_valE, m_vale);
                check("rnd_cnd", 64'(out_cnd), 64'(m_cnd));
                check("rnd_err", 64'(out_err), 64'(m_err));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
